ipm2t_hssthp_rst_rx_seq_v1_0: RTL and testbench

RX lane reset sequencer for one HSSTHP lane. Drives the PMA and PCS RX resets in order (PMA reset, CDR lock qualification, PCS reset, done). It sits directly upstream of the lane's watchdog:
- `rx_rst_done` drives the watchdog's activity input (watchdog built with `ACTIVE_HIGH=1`).
- `wtchdg_clr` drives the watchdog's clear input.
- The watchdog's `wtchdg_rst_n` feeds back into this block and forces a full restart when the link fails to come up.

---
 rtl/ipm2t_hssthp_rst_rx_seq_v1_0.sv | 95 +++++++++
 tb/tb_ipm2t_hssthp_rst_rx_seq_v1_0.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ipm2t_hssthp_rst_rx_seq_v1_0.sv
// ipm2t_hssthp_rst_rx_seq_v1_0: RX lane reset sequencer (PMA reset, CDR lock qualification, PCS reset, done)
// Ports:
//   clk, rst_n                 sequencer clock, asynchronous active-low reset
//   rx_rst_req, wtchdg_rst_n   user restart (high) and watchdog restart (low)
//   rx_los, cdr_lock           link status, already synchronous to clk
//   pma_rx_rst, pcs_rx_rst     PMA/PCS RX resets, active high
//   rx_rst_done, wtchdg_clr    lane up, one-cycle watchdog clear on every PMA_RST entry
//   rx_fsm_st, wd_retry_cnt    state encoding, saturating watchdog restart count
module ipm2t_hssthp_rst_rx_seq_v1_0 #(
  parameter int PMA_RST_CNTR_WIDTH   = 8,
  parameter int LOCK_STBL_CNTR_WIDTH = 10,
  parameter int PCS_RST_CNTR_WIDTH   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rst_req,
  input  logic       wtchdg_rst_n,
  input  logic       rx_los,
  input  logic       cdr_lock,
  output logic       pma_rx_rst,
  output logic       pcs_rx_rst,
  output logic       rx_rst_done,
  output logic       wtchdg_clr,
  output logic [2:0] rx_fsm_st,
  output logic [7:0] wd_retry_cnt
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PMA_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    PCS_RST   = 3'd3,
    DONE      = 3'd4
  } state_t;
  localparam logic [PMA_RST_CNTR_WIDTH:0] PMA_LAST = {1'b0, {PMA_RST_CNTR_WIDTH{1'b1}}};
  localparam logic [PCS_RST_CNTR_WIDTH:0] PCS_LAST = {1'b0, {PCS_RST_CNTR_WIDTH{1'b1}}};
  state_t                          state_q, state_d;
  logic [PMA_RST_CNTR_WIDTH:0]     pma_cnt_q, pma_cnt_d;
  logic [LOCK_STBL_CNTR_WIDTH-1:0] stbl_cnt_q, stbl_cnt_d;
  logic [PCS_RST_CNTR_WIDTH:0]     pcs_cnt_q, pcs_cnt_d;
  logic [7:0]                      wd_q, wd_d;
  logic                            restart, restart_q, lock_ok, stay;
  logic                            pma_d, pcs_d, done_d, clr_d;
  always_comb begin
    restart = (state_q != IDLE) && (rx_rst_req || !wtchdg_rst_n);
    lock_ok = cdr_lock && !rx_los;
    state_d = state_q;
    if (restart) state_d = PMA_RST;
    else
      case (state_q)
        IDLE:      state_d = PMA_RST;
        PMA_RST:   state_d = (pma_cnt_q == PMA_LAST) ? WAIT_LOCK : PMA_RST;
        WAIT_LOCK: state_d = (lock_ok && &stbl_cnt_q) ? PCS_RST : WAIT_LOCK;
        PCS_RST:   state_d = !lock_ok ? WAIT_LOCK : (pcs_cnt_q == PCS_LAST) ? DONE : PCS_RST;
        DONE:      state_d = lock_ok ? DONE : WAIT_LOCK;
        default:   state_d = PMA_RST;
      endcase
    // a restart reloads the local counter even when the state does not change
    stay       = (state_d == state_q) && !restart;
    pma_cnt_d  = (stay && state_q == PMA_RST) ? pma_cnt_q + 1'b1 : '0;
    stbl_cnt_d = (stay && state_q == WAIT_LOCK && lock_ok) ? stbl_cnt_q + 1'b1 : '0;
    pcs_cnt_d  = (stay && state_q == PCS_RST) ? pcs_cnt_q + 1'b1 : '0;
    // re-entry pulses only on the rising edge of the restart condition, so a held level pulses once
    clr_d      = (state_d == PMA_RST) && ((state_q != PMA_RST) || (restart && !restart_q));
    wd_d       = (clr_d && restart && !rx_rst_req && wd_q != 8'hff) ? wd_q + 1'b1 : wd_q;
    pma_d      = (state_d == IDLE) || (state_d == PMA_RST);
    pcs_d      = state_d != DONE;
    done_d     = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      pma_cnt_q   <= '0;
      stbl_cnt_q  <= '0;
      pcs_cnt_q   <= '0;
      wd_q        <= '0;
      restart_q   <= 1'b0;
      pma_rx_rst  <= 1'b1;
      pcs_rx_rst  <= 1'b1;
      rx_rst_done <= 1'b0;
      wtchdg_clr  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pma_cnt_q   <= pma_cnt_d;
      stbl_cnt_q  <= stbl_cnt_d;
      pcs_cnt_q   <= pcs_cnt_d;
      wd_q        <= wd_d;
      restart_q   <= restart;
      pma_rx_rst  <= pma_d;
      pcs_rx_rst  <= pcs_d;
      rx_rst_done <= done_d;
      wtchdg_clr  <= clr_d;
    end
  assign rx_fsm_st    = state_q;
  assign wd_retry_cnt = wd_q;
endmodule

// File: tb/tb_ipm2t_hssthp_rst_rx_seq_v1_0.sv
// tb_ipm2t_hssthp_rst_rx_seq_v1_0: directed self-checking bench for the RX lane reset sequencer
module tb_ipm2t_hssthp_rst_rx_seq_v1_0;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rst_req = 1'b0;
  logic       wtchdg_rst_n = 1'b1;
  logic       rx_los = 1'b0;
  logic       cdr_lock = 1'b1;
  logic       pma_rx_rst, pcs_rx_rst, rx_rst_done, wtchdg_clr;
  logic [2:0] rx_fsm_st;
  logic [7:0] wd_retry_cnt;
  int         checks = 0;
  int         errors = 0;
  int         clr_n = 0;
  int         pma_hi = 0;
  int         c0, p0;
  ipm2t_hssthp_rst_rx_seq_v1_0 dut (
    .clk(clk), .rst_n(rst_n), .rx_rst_req(rx_rst_req), .wtchdg_rst_n(wtchdg_rst_n),
    .rx_los(rx_los), .cdr_lock(cdr_lock), .pma_rx_rst(pma_rx_rst), .pcs_rx_rst(pcs_rx_rst),
    .rx_rst_done(rx_rst_done), .wtchdg_clr(wtchdg_clr), .rx_fsm_st(rx_fsm_st),
    .wd_retry_cnt(wd_retry_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wtchdg_clr) clr_n <= clr_n + 1;
    if (pma_rx_rst) pma_hi <= pma_hi + 1;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_pma"}, 32'(pma_rx_rst), 1);
    check({tag, "_pcs"}, 32'(pcs_rx_rst), 1);
    check({tag, "_done"}, 32'(rx_rst_done), 0);
    check({tag, "_clr"}, 32'(wtchdg_clr), 0);
    check({tag, "_st"}, 32'(rx_fsm_st), 0);
    check({tag, "_wd"}, 32'(wd_retry_cnt), 0);
  endtask
  initial begin
    #12;
    check_rst("rst");
    @(negedge clk); rst_n = 1'b1;
    c0 = clr_n;
    check("c0_st", 32'(rx_fsm_st), 0);
    tick(1);
    check("c1_st", 32'(rx_fsm_st), 1);
    check("c1_clr", 32'(wtchdg_clr), 1);
    check("c1_pma", 32'(pma_rx_rst), 1);
    tick(1);
    check("c2_clr", 32'(wtchdg_clr), 0);
    tick(254);
    check("c256_pma", 32'(pma_rx_rst), 1);
    tick(1);
    check("c257_pma", 32'(pma_rx_rst), 0);
    check("c257_st", 32'(rx_fsm_st), 2);
    tick(1023);
    check("c1280_st", 32'(rx_fsm_st), 2);
    tick(1);
    check("c1281_st", 32'(rx_fsm_st), 3);
    check("c1281_pcs", 32'(pcs_rx_rst), 1);
    tick(63);
    check("c1344_done", 32'(rx_rst_done), 0);
    tick(1);
    check("c1345_done", 32'(rx_rst_done), 1);
    check("c1345_pcs", 32'(pcs_rx_rst), 0);
    check("c1345_st", 32'(rx_fsm_st), 4);
    check("clr_once", 32'(clr_n - c0), 1);
    p0 = pma_hi;
    @(negedge clk); rx_los = 1'b1;
    tick(1);
    check("los_st", 32'(rx_fsm_st), 2);
    check("los_done", 32'(rx_rst_done), 0);
    check("los_pcs", 32'(pcs_rx_rst), 1);
    check("los_pma", 32'(pma_rx_rst), 0);
    tick(2);
    @(negedge clk); rx_los = 1'b0;
    tick(1087);
    check("los_rec_pre", 32'(rx_rst_done), 0);
    check("los_rec_pre_st", 32'(rx_fsm_st), 3);
    tick(1);
    check("los_rec_done", 32'(rx_rst_done), 1);
    check("los_no_pma", 32'(pma_hi - p0), 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick(1300);
    check("pcs_st", 32'(rx_fsm_st), 3);
    #2 rst_n = 1'b0;
    #1 check_rst("arst");
    @(negedge clk); rst_n = 1'b1;
    tick(300);
    check("g_wait_st", 32'(rx_fsm_st), 2);
    p0 = pma_hi;
    @(negedge clk); cdr_lock = 1'b0;
    @(negedge clk); cdr_lock = 1'b1;
    check("g_st", 32'(rx_fsm_st), 2);
    tick(1087);
    check("g_pre_done", 32'(rx_rst_done), 0);
    check("g_pre_st", 32'(rx_fsm_st), 3);
    tick(1);
    check("g_done", 32'(rx_rst_done), 1);
    check("g_no_pma", 32'(pma_hi - p0), 0);
    @(negedge clk); cdr_lock = 1'b0;
    tick(1);
    check("unlock_st", 32'(rx_fsm_st), 2);
    check("unlock_done", 32'(rx_rst_done), 0);
    c0 = clr_n;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wtchdg_rst_n = 1'b0;
      tick(1);
      check("wd_st", 32'(rx_fsm_st), 1);
      check("wd_clr", 32'(wtchdg_clr), 1);
      check("wd_pma", 32'(pma_rx_rst), 1);
      @(negedge clk); wtchdg_rst_n = 1'b1;
      tick(3);
      check("wd_clr_low", 32'(wtchdg_clr), 0);
    end
    check("wd_pulses", 32'(clr_n - c0), 3);
    check("wd_cnt3", 32'(wd_retry_cnt), 3);
    c0 = clr_n;
    @(negedge clk); rx_rst_req = 1'b1; wtchdg_rst_n = 1'b0;
    tick(1);
    check("both_clr", 32'(wtchdg_clr), 1);
    check("both_st", 32'(rx_fsm_st), 1);
    @(negedge clk); wtchdg_rst_n = 1'b1;
    tick(3);
    check("req_held_st", 32'(rx_fsm_st), 1);
    check("req_held_clr", 32'(wtchdg_clr), 0);
    @(negedge clk); rx_rst_req = 1'b0;
    tick(1);
    check("both_pulses", 32'(clr_n - c0), 1);
    check("both_wd", 32'(wd_retry_cnt), 3);
    tick(254);
    check("reload_pre", 32'(rx_fsm_st), 1);
    tick(1);
    check("reload_exit", 32'(rx_fsm_st), 2);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); wtchdg_rst_n = 1'b0;
      @(negedge clk); wtchdg_rst_n = 1'b1;
    end
    tick(1);
    check("wd_sat", 32'(wd_retry_cnt), 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
